// File: rtl/fetch_buffer.sv
// 3-wide circular instruction queue between fetch and dispatch.
// Packet layout: {valid, pc[PcW-1:0], inst[InstW-1:0]}; slot 2 is always the oldest.
module fetch_buffer #(
  parameter int unsigned Depth = 8,
  parameter int unsigned PcW   = 32,
  parameter int unsigned InstW = 32,
  localparam int unsigned PktW = 1 + PcW + InstW,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [2:0][PktW-1:0] fch_ifid_pkts_i,
  input  logic                 fb_flush_i,
  input  logic [1:0]           dis_take_i,
  output logic [2:0]           fch_dispatch_stall_o,
  output logic [2:0][PktW-1:0] dis_pkts_o,
  output logic [CntW-1:0]      fb_count_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned DataW = PcW + InstW;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [2:0]       stall, accept;
  logic [1:0]       enq_n, deq_n;

  // Stall depends only on registered occupancy: no input-to-stall path.
  assign stall[2] = (count_q >= CntW'(Depth));
  assign stall[1] = (count_q >= CntW'(Depth - 1));
  assign stall[0] = (count_q >= CntW'(Depth - 2));
  assign fch_dispatch_stall_o = stall;
  assign fb_count_o = count_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      accept[i] = fch_ifid_pkts_i[i][PktW-1] & ~stall[i];
    end
  end

  assign enq_n = {1'b0, accept[2]} + {1'b0, accept[1]} + {1'b0, accept[0]};

  always_comb begin
    deq_n = dis_take_i;
    if ((count_q < CntW'(3)) && (CntW'(dis_take_i) > count_q)) begin
      deq_n = count_q[1:0];
    end
  end

  always_comb begin
    head_d  = head_q + PtrW'(deq_n);
    tail_d  = tail_q + PtrW'(enq_n);
    count_d = count_q + CntW'(enq_n) - CntW'(deq_n);
    if (fb_flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Accepted slots are contiguous from slot 2, so slot 2-k lands at tail+k.
  always_ff @(posedge clk_i) begin
    if (!fb_flush_i) begin
      for (int k = 0; k < 3; k++) begin
        if (accept[2-k]) begin
          mem_q[tail_q + PtrW'(k)] <= fch_ifid_pkts_i[2-k][DataW-1:0];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dis_pkts_o[2-k] = '0;
      if (count_q > CntW'(k)) begin
        dis_pkts_o[2-k] = {1'b1, mem_q[head_q + PtrW'(k)]};
      end
    end
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- 3-wide circular instruction queue between fetch_stage and dispatch.
- Enqueues up to three IF_ID_PACKETs per cycle from fetch and presents the oldest three entries to dispatch.
- Returns per-slot back-pressure (fch_dispatch_stall) to fetch.
- Flushed on branch recovery.

Parameters:
- DEPTH, 8, number of packet entries; power of two, at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; buffer is cleared while rst==0.
- fch_ifid_pkts  in  IF_ID_PACKET[2:0]  packets from fetch; slot 2 is the oldest (lowest PC).
- fb_flush  in  1  squash all contents (branch recovery / icache_branch).
- dis_take  in  2  number of oldest presented packets dispatch consumes this cycle (0..3).
- fch_dispatch_stall  out  3  per-slot back-pressure to fetch; bit 2 is the oldest slot.
- dis_pkts  out  IF_ID_PACKET[2:0]  oldest three buffered packets; slot 2 is the head.
- fb_count  out  $clog2(DEPTH+1)  current occupancy, registered.

Behaviour:
- State:
  - entries[DEPTH]
  - head and tail pointers, log2(DEPTH) bits each, wrapping modulo DEPTH
  - count, 0..DEPTH
- Reset, asynchronous, while rst==0:
  - head=tail=count=0; entry contents don't-care.
  - Outputs: fch_dispatch_stall=3'b000, dis_pkts all zero with valid=0, fb_count=0.
- Free space:
  - free = DEPTH - count, using the registered count only (no same-cycle dequeue credit).
  - stall[2] = (free<1); stall[1] = (free<2); stall[0] = (free<3).
  - Stall is a pure function of registered state, so there is no combinational path from any input to the stall outputs.
- Enqueue:
  - Accepted slot i iff fch_ifid_pkts[i].valid && !stall[i].
  - Valid bits from fetch are contiguous from slot 2 downward.
  - enq_n = number of accepted slots (0..3).
  - Accepted packets are written in order 2,1,0 at tail, tail+1, tail+2 (mod DEPTH); tail advances by enq_n.
- Dequeue:
  - deq_n = min(dis_take, count).
  - Head advances by deq_n; consumed entries are not cleared.
- Presentation:
  - dis_pkts[2-k] = entries[head+k], valid = (count>k), for k = 0,1,2.
  - Slots with valid=0 drive all-zero fields.
  - Driven combinationally from registered state.
- Latency:
  - A packet enqueued at edge N is visible on dis_pkts after edge N; 1-cycle minimum.
  - No bypass from fch_ifid_pkts to dis_pkts when empty.
- Count update: count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue is legal at any occupancy.
- Flush priority, fb_flush==1 at an edge:
  - head=tail=count=0.
  - Same-cycle enqueue and dequeue are discarded.
  - Stall outputs in that cycle still reflect pre-flush count.
  - Next cycle: stall=000, all dis_pkts invalid.
- Full (count==DEPTH): stall=111, nothing accepted; dequeue still proceeds.
- Near-full:
  - count==DEPTH-1: stall=011, only slot 2 accepted.
  - count==DEPTH-2: stall=001.
- Empty (count==0): all dis_pkts invalid; dis_take ignored (deq_n=0).
- dis_take greater than count: clamped; never underflows.
- Wrap-around: pointer arithmetic modulo DEPTH; a 3-packet enqueue may straddle entry DEPTH-1 to entry 0.
- Reset mid-operation: immediate clear regardless of clk; resumes cleanly on the first edge after rst returns to 1.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> fb_count=0, stall=000, all dis_pkts.valid=0.
- Fill, DEPTH=8, dis_take=0, three valid packets per cycle with PCs 0,4,8; 12,16,20; ...:
  - After 2 edges: count=6, stall=001.
  - Third edge accepts only PCs 24,28 -> count=8, stall=111.
  - dis_pkts PCs = 0,4,8.
- Simultaneous at full: count=8, dis_take=3, fetch offers 3 -> stall=111, enq_n=0; next cycle count=5, dis_pkts PCs 12,16,20.
- Wrap:
  - Start from count=0, head=tail=6.
  - Enqueue PCs 100,104,108 -> written to entries 6,7,0; tail=1.
  - Next cycle dis_pkts PCs 100,104,108 in slots 2,1,0.
- Partial and clamp: count=1 (PC 40), dis_take=3 -> deq_n=1, count=0; same cycle fetch valid=3'b100 (PC 44) -> next cycle count=1, dis_pkts[2].PC=44, slots 1,0 invalid.
- Flush: count=5 with fb_flush=1, fetch offers 3, dis_take=2 -> next cycle count=0, stall=000, all invalid; following enqueue of PC 200 appears at dis_pkts[2].
